// File: rtl/dpram_pkg.sv
// Shared types and constants for the dual-port RAM collision controller.
package dpram_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 6;

  // Arbitration state: free-running round robin, or a port is owed the next win
  typedef enum logic [1:0] {
    FREE  = 2'b00,
    OWE_A = 2'b01,
    OWE_B = 2'b10
  } coll_state_e;

  // One client request at the default bus widths
  typedef struct packed {
    logic                      we;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } mem_req_t;

  // Saturating 16-bit increment used by the statistics counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dpram_rvalid_gen.sv
// Per-port read-data-valid strobe: the memory returns data one cycle after
// an accepted read, so the strobe is the accepted-read flag delayed by one.
module dpram_rvalid_gen
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_fire,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] q
);

  logic rvalid_r;

  // Delay the accepted-read flag by one cycle to line up with memory data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= rd_fire;
    end
  end

  assign rvalid = rvalid_r;
  assign q      = mem_q;

endmodule

// File: rtl/dpram_collision_ctrl.sv
// Same-address collision controller between two clients and a dual-port RAM.
// Conflicting same-cycle requests (same address, at least one write) are
// serialized; the loser is owed the next win so it never starves.
// Optional statistics outputs are enabled with DPRAM_COLL_STATS_EN.
module dpram_collision_ctrl
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic [DATA_WIDTH-1:0] a_q,
  output logic                  a_rvalid,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [DATA_WIDTH-1:0] b_q,
  output logic                  b_rvalid,
  output logic                  mem_valid_a,
  output logic                  mem_we_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [DATA_WIDTH-1:0] mem_data_a,
  input  logic                  mem_ready_a,
  input  logic [DATA_WIDTH-1:0] mem_q_a,
  output logic                  mem_valid_b,
  output logic                  mem_we_b,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic [DATA_WIDTH-1:0] mem_data_b,
  input  logic                  mem_ready_b,
  input  logic [DATA_WIDTH-1:0] mem_q_b
`ifdef DPRAM_COLL_STATS_EN
  ,
  output logic [15:0]           conflict_count,
  output logic [15:0]           stall_cycles
`endif
);

  coll_state_e state_r, state_nxt_s;
  logic        prio_r, prio_nxt_s;
  logic        conflict_s, winner_b_s;
  logic        stall_a_s, stall_b_s;
  logic        fire_a_s, fire_b_s, resolve_s;

  assign conflict_s = a_valid & b_valid & (a_addr == b_addr) & (a_we | b_we);

  // Pick the conflict winner: an owed port wins, otherwise round robin
  always_comb begin
    winner_b_s = 1'b0;
    case (state_r)
      FREE:    winner_b_s = prio_r;
      OWE_A:   winner_b_s = 1'b0;
      OWE_B:   winner_b_s = 1'b1;
      default: winner_b_s = prio_r;
    endcase
  end

  assign stall_a_s = conflict_s & winner_b_s;
  assign stall_b_s = conflict_s & ~winner_b_s;

  assign mem_valid_a = rst_n & a_valid & ~stall_a_s;
  assign mem_valid_b = rst_n & b_valid & ~stall_b_s;
  assign a_ready     = rst_n & mem_ready_a & ~stall_a_s;
  assign b_ready     = rst_n & mem_ready_b & ~stall_b_s;

  assign mem_we_a   = a_we;
  assign mem_addr_a = a_addr;
  assign mem_data_a = a_data;
  assign mem_we_b   = b_we;
  assign mem_addr_b = b_addr;
  assign mem_data_b = b_data;

  assign fire_a_s  = mem_valid_a & mem_ready_a;
  assign fire_b_s  = mem_valid_b & mem_ready_b;
  assign resolve_s = conflict_s & (winner_b_s ? fire_b_s : fire_a_s);

  // Advance arbitration only when a memory handshake actually completes
  always_comb begin
    state_nxt_s = state_r;
    prio_nxt_s  = prio_r;
    if (resolve_s) begin
      if (winner_b_s) begin
        state_nxt_s = OWE_A;
        prio_nxt_s  = 1'b0;
      end else begin
        state_nxt_s = OWE_B;
        prio_nxt_s  = 1'b1;
      end
    end else if ((state_r == OWE_A) && fire_a_s) begin
      state_nxt_s = FREE;
    end else if ((state_r == OWE_B) && fire_b_s) begin
      state_nxt_s = FREE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Arbitration state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FREE;
      prio_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      prio_r  <= prio_nxt_s;
    end
  end

  dpram_rvalid_gen #(.DATA_WIDTH(DATA_WIDTH)) u_rvalid_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_fire (a_valid & a_ready & ~a_we),
    .mem_q   (mem_q_a),
    .rvalid  (a_rvalid),
    .q       (a_q)
  );

  dpram_rvalid_gen #(.DATA_WIDTH(DATA_WIDTH)) u_rvalid_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_fire (b_valid & b_ready & ~b_we),
    .mem_q   (mem_q_b),
    .rvalid  (b_rvalid),
    .q       (b_q)
  );

`ifdef DPRAM_COLL_STATS_EN
  logic [15:0] conflict_count_r, stall_cycles_r;

  // Saturating counts of resolved conflicts and conflict-stall cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_count_r <= 16'd0;
      stall_cycles_r   <= 16'd0;
    end else begin
      if (resolve_s) begin
        conflict_count_r <= sat_inc16(conflict_count_r);
      end else begin
        conflict_count_r <= conflict_count_r;
      end
      if (conflict_s) begin
        stall_cycles_r <= sat_inc16(stall_cycles_r);
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
    end
  end

  assign conflict_count = conflict_count_r;
  assign stall_cycles   = stall_cycles_r;
`endif

endmodule

// File: tb/tb_dpram_collision_ctrl.sv
// Scoreboard bench for dpram_collision_ctrl: directed scenarios followed by
// randomized two-client traffic against a behavioural memory model.
module tb_dpram_collision_ctrl;

  localparam int DW = 8;
  localparam int AW = 6;

  typedef struct {
    logic          v;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_ready, a_we, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data, a_q;
  logic          b_valid, b_ready, b_we, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data, b_q;
  logic          mem_valid_a, mem_we_a, mem_ready_a;
  logic [AW-1:0] mem_addr_a;
  logic [DW-1:0] mem_data_a, mem_q_a;
  logic          mem_valid_b, mem_we_b, mem_ready_b;
  logic [AW-1:0] mem_addr_b;
  logic [DW-1:0] mem_data_b, mem_q_b;
`ifdef DPRAM_COLL_STATS_EN
  logic [15:0]   conflict_count, stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] dmem    [0:63];  // the RAM behind the controller
  logic [DW-1:0] ref_mem [0:63];  // what the clients should observe
  exp_t          qa[$];
  exp_t          qb[$];
  int            owed;            // 0 none, 1 A owed, 2 B owed
  bit            rr_b;            // round-robin favours B
  logic [15:0]   exp_conf, exp_stall;

  always #5 clk = ~clk;

  dpram_collision_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_data(a_data), .a_q(a_q), .a_rvalid(a_rvalid),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_data(b_data), .b_q(b_q), .b_rvalid(b_rvalid),
    .mem_valid_a(mem_valid_a), .mem_we_a(mem_we_a), .mem_addr_a(mem_addr_a),
    .mem_data_a(mem_data_a), .mem_ready_a(mem_ready_a), .mem_q_a(mem_q_a),
    .mem_valid_b(mem_valid_b), .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b),
    .mem_data_b(mem_data_b), .mem_ready_b(mem_ready_b), .mem_q_b(mem_q_b)
`ifdef DPRAM_COLL_STATS_EN
    , .conflict_count(conflict_count), .stall_cycles(stall_cycles)
`endif
  );

  // Dual-port RAM model with one-cycle read latency
  always @(posedge clk) begin
    if (mem_valid_a && mem_ready_a) begin
      if (mem_we_a) dmem[mem_addr_a] <= mem_data_a;
      else          mem_q_a <= dmem[mem_addr_a];
    end
    if (mem_valid_b && mem_ready_b) begin
      if (mem_we_b) dmem[mem_addr_b] <= mem_data_b;
      else          mem_q_b <= dmem[mem_addr_b];
    end
  end

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chkw(name, 32'(act), 32'(exp));
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic req_t mk(input logic v, input logic we, input int addr, input int data);
    req_t r;
    r.v = v; r.we = we; r.addr = AW'(addr); r.data = DW'(data);
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.v    = ($urandom_range(0, 3) != 0);
    r.we   = 1'($urandom_range(0, 1));
    r.addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 3));
    r.data = DW'($urandom_range(0, 255));
    return r;
  endfunction

  // One clock cycle: drive both clients, check the request path, update the model
  task automatic do_cycle(input logic rst, input req_t ra, input req_t rb,
                          input logic mra, input logic mrb,
                          output logic acc_a, output logic acc_b);
    logic conflict, wb, ea, eb;
    exp_t e;
    @(negedge clk);
    cyc++;
    rst_n = rst;
    a_valid = ra.v; a_we = ra.we; a_addr = ra.addr; a_data = ra.data;
    b_valid = rb.v; b_we = rb.we; b_addr = rb.addr; b_data = rb.data;
    mem_ready_a = mra; mem_ready_b = mrb;
    #1;
`ifdef DPRAM_COLL_STATS_EN
    chkw("conflict_count", 32'(conflict_count), 32'(exp_conf));
    chkw("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
`endif
    conflict = ra.v && rb.v && (ra.addr == rb.addr) && (ra.we || rb.we);
    wb = (owed == 2) ? 1'b1 : (owed == 1) ? 1'b0 : rr_b;
    if (!rst) begin
      chkb("rst_a_ready", a_ready, 1'b0);
      chkb("rst_b_ready", b_ready, 1'b0);
      chkb("rst_mem_valid_a", mem_valid_a, 1'b0);
      chkb("rst_mem_valid_b", mem_valid_b, 1'b0);
      ea = 1'b0; eb = 1'b0;
      owed = 0; rr_b = 1'b0; exp_conf = 16'd0; exp_stall = 16'd0;
    end else begin
      ea = ra.v && mra && !(conflict && wb);
      eb = rb.v && mrb && !(conflict && !wb);
      chkb("a_ready", a_ready, mra && !(conflict && wb));
      chkb("b_ready", b_ready, mrb && !(conflict && !wb));
      chkb("mem_valid_a", mem_valid_a, ra.v && !(conflict && wb));
      chkb("mem_valid_b", mem_valid_b, rb.v && !(conflict && !wb));
      if (ra.v && !(conflict && wb)) begin
        chkw("mem_fields_a", {23'd0, mem_we_a, mem_addr_a, mem_data_a} & 32'h7FFF,
             {23'd0, ra.we, ra.addr, ra.data} & 32'h7FFF);
      end
      if (rb.v && !(conflict && !wb)) begin
        chkw("mem_fields_b", {23'd0, mem_we_b, mem_addr_b, mem_data_b} & 32'h7FFF,
             {23'd0, rb.we, rb.addr, rb.data} & 32'h7FFF);
      end
      if (mem_valid_a && mem_valid_b && (mem_addr_a == mem_addr_b) && (mem_we_a || mem_we_b)) begin
        chkb("mem_collision", 1'b1, 1'b0);
      end
      if (conflict) begin
        exp_stall = sat16(exp_stall);
        if ((wb && eb) || (!wb && ea)) begin
          exp_conf = sat16(exp_conf);
          owed = wb ? 1 : 2;
          rr_b = !wb;
        end
      end else begin
        if (owed == 1 && ea) owed = 0;
        else if (owed == 2 && eb) owed = 0;
      end
      if (ea && !ra.we) begin e.due = cyc + 1; e.data = ref_mem[ra.addr]; qa.push_back(e); end
      if (eb && !rb.we) begin e.due = cyc + 1; e.data = ref_mem[rb.addr]; qb.push_back(e); end
      if (ea && ra.we) ref_mem[ra.addr] = ra.data;
      if (eb && rb.we) ref_mem[rb.addr] = rb.data;
    end
    acc_a = ra.v && a_ready;
    acc_b = rb.v && b_ready;
  endtask

  // Monitor: compare every read-data strobe against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (qa.size() > 0 && qa[0].due == cyc) begin
        e = qa.pop_front();
        chkb("a_rvalid", a_rvalid, 1'b1);
        if (a_rvalid === 1'b1) chkw("a_q", 32'(a_q), 32'(e.data));
      end else if (cyc > 0) begin
        chkb("a_rvalid_idle", a_rvalid, 1'b0);
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        e = qb.pop_front();
        chkb("b_rvalid", b_rvalid, 1'b1);
        if (b_rvalid === 1'b1) chkw("b_q", 32'(b_q), 32'(e.data));
      end else if (cyc > 0) begin
        chkb("b_rvalid_idle", b_rvalid, 1'b0);
      end
    end
  end

  initial begin
    req_t idle, pa, pb, wa, rb;
    logic aa, ab;
    bit   t4_b_first [0:3];
    t4_b_first[0] = 1'b1; t4_b_first[1] = 1'b0; t4_b_first[2] = 1'b1; t4_b_first[3] = 1'b0;
    idle = mk(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 64; i++) begin
      dmem[i] = DW'($urandom_range(0, 255));
      ref_mem[i] = dmem[i];
    end
    mem_q_a = '0; mem_q_b = '0;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    mem_ready_a = 1'b1; mem_ready_b = 1'b1;
    owed = 0; rr_b = 1'b0; exp_conf = 16'd0; exp_stall = 16'd0;

    // Reset with requests present: nothing may be accepted
    do_cycle(1'b0, mk(1'b1, 1'b0, 3, 0), mk(1'b1, 1'b1, 3, 5), 1'b1, 1'b1, aa, ab);
    do_cycle(1'b0, idle, idle, 1'b1, 1'b1, aa, ab);

    // Different-address writes pass straight through, then read back
    do_cycle(1'b1, mk(1'b1, 1'b1, 5, 8'h11), mk(1'b1, 1'b1, 9, 8'h22), 1'b1, 1'b1, aa, ab);
    chkb("t1_wr_a_acc", aa, 1'b1); chkb("t1_wr_b_acc", ab, 1'b1);
    do_cycle(1'b1, mk(1'b1, 1'b0, 5, 0), mk(1'b1, 1'b0, 9, 0), 1'b1, 1'b1, aa, ab);
    chkb("t1_rd_a_acc", aa, 1'b1); chkb("t1_rd_b_acc", ab, 1'b1);

    // Read-read to one address is not a conflict
    do_cycle(1'b1, mk(1'b1, 1'b0, 3, 0), mk(1'b1, 1'b0, 3, 0), 1'b1, 1'b1, aa, ab);
    chkb("t2_a_acc", aa, 1'b1); chkb("t2_b_acc", ab, 1'b1);

    // Write-write conflict after reset: A first, B's data is final
    do_cycle(1'b0, idle, idle, 1'b1, 1'b1, aa, ab);
    do_cycle(1'b1, mk(1'b1, 1'b1, 7, 8'hAA), mk(1'b1, 1'b1, 7, 8'hBB), 1'b1, 1'b1, aa, ab);
    chkb("t3_a_acc_c0", aa, 1'b1); chkb("t3_b_acc_c0", ab, 1'b0);
    do_cycle(1'b1, idle, mk(1'b1, 1'b1, 7, 8'hBB), 1'b1, 1'b1, aa, ab);
    chkb("t3_b_acc_c1", ab, 1'b1);
`ifdef DPRAM_COLL_STATS_EN
    chkw("t3_conflict_count", 32'(conflict_count), 32'd1);
`endif
    do_cycle(1'b1, mk(1'b1, 1'b0, 7, 0), idle, 1'b1, 1'b1, aa, ab);

    // Back-to-back write/read conflicts on addr 2 alternate winners B, A, B, A
    for (int i = 0; i < 4; i++) begin
      wa = mk(1'b1, 1'b1, 2, 8'h30 + i);
      rb = mk(1'b1, 1'b0, 2, 0);
      do_cycle(1'b1, wa, rb, 1'b1, 1'b1, aa, ab);
      chkb("t4_a_first", aa, !t4_b_first[i]);
      chkb("t4_b_first", ab, t4_b_first[i]);
      if (t4_b_first[i]) do_cycle(1'b1, wa, idle, 1'b1, 1'b1, aa, ab);
      else               do_cycle(1'b1, idle, rb, 1'b1, 1'b1, aa, ab);
      chkb("t4_second", t4_b_first[i] ? aa : ab, 1'b1);
    end

    // Hand the round robin to A, then stall A at the memory for 3 cycles
    do_cycle(1'b1, mk(1'b1, 1'b0, 10, 0), mk(1'b1, 1'b1, 10, 8'h66), 1'b1, 1'b1, aa, ab);
    chkb("t5_pre_b", ab, 1'b1);
    do_cycle(1'b1, mk(1'b1, 1'b0, 10, 0), idle, 1'b1, 1'b1, aa, ab);
    wa = mk(1'b1, 1'b1, 10, 8'h5A);
    rb = mk(1'b1, 1'b0, 10, 0);
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b1, wa, rb, 1'b0, 1'b1, aa, ab);
      chkb("t5_hold_a", aa, 1'b0); chkb("t5_hold_b", ab, 1'b0);
    end
    do_cycle(1'b1, wa, rb, 1'b1, 1'b1, aa, ab);
    chkb("t5_a_acc", aa, 1'b1); chkb("t5_b_wait", ab, 1'b0);
    do_cycle(1'b1, idle, rb, 1'b1, 1'b1, aa, ab);
    chkb("t5_b_acc", ab, 1'b1);

    // Reset in the middle of a conflict: round robin returns to A
    wa = mk(1'b1, 1'b1, 12, 8'h77);
    rb = mk(1'b1, 1'b0, 12, 0);
    do_cycle(1'b0, wa, rb, 1'b1, 1'b1, aa, ab);
    do_cycle(1'b1, wa, rb, 1'b1, 1'b1, aa, ab);
    chkb("t6_a_acc", aa, 1'b1); chkb("t6_b_stall", ab, 1'b0);
    do_cycle(1'b1, idle, rb, 1'b1, 1'b1, aa, ab);
    chkb("t6_b_acc", ab, 1'b1);

    // Randomized traffic with memory back-pressure and occasional reset
    pa = idle; pb = idle; aa = 1'b0; ab = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic rst;
      if (!pa.v || aa) pa = rand_req();
      if (!pb.v || ab) pb = rand_req();
      rst = ($urandom_range(0, 299) != 0);
      do_cycle(rst, pa, pb, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8), aa, ab);
      if (!rst) begin pa.v = 1'b0; pb.v = 1'b0; end
    end

    for (int n = 0; n < 3; n++) do_cycle(1'b1, idle, idle, 1'b1, 1'b1, aa, ab);
    chkw("qa_drained", qa.size(), 32'd0);
    chkw("qb_drained", qb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
